mem_error_reporter: RTL
=======================

// Module: mem_error_reporter
// PURPOSE
//  Consumer side of the memory error detector's error/interrupt interface. When the held
//  error vector is non-zero, takes a snapshot, emits one record per set flag over a
//  valid/ready stream to the host/fault logger, then pulses interrupt to return the
//  detector to idle. Sits between the memory error detector of the systolic array
//  and the fault-handling controller.
// PARAMETERS
//  arraySize  4   flags per memory group; 6 groups (z,y,x,w,e,abcd) -> 6*arraySize flags
//  CNT_W      16  width of accepted-record counter (optional feature only)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             asynchronous, active-low reset
//  enable     in   1             1 = reporter may capture new error vectors
//  error      in   6*arraySize   held error flags from detector; bit k: group k/arraySize, index k%arraySize
//  interrupt  out  1             one-cycle pulse to detector: errors consumed, return to idle
//  rec_valid  out  1             record available
//  rec_ready  in   1             host accepts record
//  rec_group  out  3             0=z 1=y 2=x 3=w 4=e 5=abcd
//  rec_index  out  $clog2(arraySize) (min 1)  PE/column index within group
//  rec_last   out  1             record is last set flag of the snapshot
//  busy       out  1             state != IDLE
//  err_count  out  CNT_W         accepted-record count (see CONFIGURATION)
//  cnt_clr    in   1             synchronous clear of err_count
// BEHAVIOUR
//  Reset: state=IDLE, snapshot=0, interrupt=0, rec_valid=0, rec_group/rec_index/rec_last=0, busy=0, err_count=0.
//  All outputs registered or decoded from registered state/snapshot only; no combinational
//  path from error/rec_ready to rec_* outputs.
//  FSM IDLE -> SEND -> IRQ -> WAIT_CLR -> IDLE:
//   IDLE: if enable && error!=0: snapshot<=error, ->SEND. rec_valid valid the cycle after capture (latency 1).
//   SEND: rec_valid=1; record = lowest set bit of snapshot (priority LSB first).
//         rec_group=k/arraySize, rec_index=k%arraySize, rec_last=(exactly one bit set).
//         On rec_valid&&rec_ready: clear bit k; if it was last ->IRQ, else next record next cycle.
//         While rec_ready=0 record held stable; one record per cycle max throughput.
//   IRQ: interrupt=1 for exactly one cycle, ->WAIT_CLR.
//   WAIT_CLR: interrupt=0; stay until error==0 (detector clears ~2 cycles after pulse), ->IDLE.
//         Prevents re-reporting the same held vector.
//  error changes during SEND are ignored (snapshot only). enable deassert mid-SEND does not abort.
//  enable=0 in IDLE: no capture, interrupt never asserted.
//  Async reset mid-SEND: record dropped, rec_valid=0 immediately, no interrupt issued.
// CONFIGURATION
//  MEM_ERR_REPORTER_COUNT_EN defined: err_count increments on every rec_valid&&rec_ready,
//   saturates at 2^CNT_W-1, cnt_clr clears to 0 (clear wins over simultaneous increment).
//  Not defined: counter not built; err_count tied to 0, cnt_clr ignored.
// TESTING (arraySize=4, CNT_W=16 unless noted)
//  1 error=24'h000011, enable=1, rec_ready=1 -> records (g0,i0,last0) then (g1,i0,last1) on consecutive
//    cycles, interrupt pulse 1 cycle later, WAIT_CLR until error=0, then IDLE.
//  2 error=24'h800000, rec_ready low 3 cycles -> rec_valid=1 with g5,i3,last=1 held stable 3 cycles;
//    accepted cycle 4; single interrupt pulse.
//  3 enable=0, error=24'h000001 for 10 cycles -> no rec_valid, no interrupt, busy=0.
//  4 error held nonzero for 5 cycles after interrupt -> no second capture until error returns to 0.
//  5 rst low during SEND of 3-flag snapshot -> all outputs at reset values, no interrupt after release.
//  6 MEM_ERR_REPORTER_COUNT_EN, CNT_W=2, 5 records accepted -> err_count 1,2,3,3,3;
//    cnt_clr -> 0; without macro err_count stays 0.

Source files
------------

// File: rtl/mem_error_reporter.sv
// mem_error_reporter
//   Consumer side of the memory error detector's error/interrupt handshake.
//   When the held error vector is non-zero, it is captured into a snapshot.
//   One record is streamed per set flag, lowest flag first, over a
//   valid/ready interface. Afterwards a one-cycle interrupt returns the
//   detector to idle. The block then waits for the error vector to clear
//   before it may capture again.
//   Optional feature: define MEM_ERR_REPORTER_COUNT_EN to build a saturating
//   counter of accepted records on err_count. When it is undefined,
//   err_count is tied to zero and cnt_clr is ignored.
module mem_error_reporter #(
  parameter int unsigned arraySize = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = (arraySize > 1) ? $clog2(arraySize) : 1,
  localparam int unsigned NFLAG    = 6 * arraySize
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [NFLAG-1:0] error,
  output logic             interrupt,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_group,
  output logic [IDX_W-1:0] rec_index,
  output logic             rec_last,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  input  logic             cnt_clr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    IRQ      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NFLAG-1:0] snap_q, snap_d;

  logic [NFLAG-1:0] snap_rest;
  logic [2:0]       sel_group;
  logic [IDX_W-1:0] sel_index;
  logic             sel_found;
  logic             accept;

  // Snapshot with its lowest set flag removed; it is empty when that flag was the last one.
  assign snap_rest = snap_q & (snap_q - NFLAG'(1));

  // Priority decode of the lowest set snapshot flag into group/index.
  always_comb begin
    sel_group = '0;
    sel_index = '0;
    sel_found = 1'b0;
    for (int unsigned k = 0; k < NFLAG; k++) begin
      if (!sel_found && snap_q[k]) begin
        sel_found = 1'b1;
        sel_group = 3'(k / arraySize);
        sel_index = IDX_W'(k % arraySize);
      end
    end
  end

  // Outputs are decoded from registered state and snapshot only.
  assign rec_valid = (state_q == SEND);
  assign rec_group = rec_valid ? sel_group : '0;
  assign rec_index = rec_valid ? sel_index : '0;
  assign rec_last  = rec_valid && (snap_q != '0) && (snap_rest == '0);
  assign interrupt = (state_q == IRQ);
  assign busy      = (state_q != IDLE);
  assign accept    = rec_valid && rec_ready;

  // Next-state and snapshot update.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (error != '0)) begin
          snap_d  = error;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rec_ready) begin
          snap_d = snap_rest;
          if (rec_last) state_d = IRQ;
        end
      end
      IRQ: begin
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (error == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        snap_d  = '0;
      end
    endcase
  end

  // State and snapshot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
    end
  end

`ifdef MEM_ERR_REPORTER_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of accepted records; a clear wins over an increment in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = cnt_clr ^ accept;
  assign err_count = '0;
`endif

endmodule
